// File: rtl/spram_pkg.sv
// Shared types and constants for the single-port RAM wrapper: control
// states, supported read latencies and the byte-lane count helper.
package spram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int lane_count(input int width, input int byte_w);
    return width / byte_w;
  endfunction

endpackage

// File: rtl/spram_core.sv
// Byte-enabled single-port array, read-first, with a registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module spram_core #(
  parameter int numwords   = 256,
  parameter int widthad    = 8,
  parameter int width      = 32,
  parameter int byte_width = 8,
  parameter int lanes      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [widthad-1:0]  addr,
  input  logic [width-1:0]    wdata,
  input  logic [lanes-1:0]    be,
  output logic [width-1:0]    q
);

  localparam int DEPTH = 1 << widthad;

  logic [width-1:0] mem [DEPTH];
  logic             in_range;

  assign in_range = (int'(addr) < numwords);

  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      for (int i = 0; i < lanes; i++) begin
        if (be[i]) begin
          mem[addr][i*byte_width +: byte_width] <= wdata[i*byte_width +: byte_width];
        end
      end
    end
  end

  // Stage p0: registered read; old contents win on a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (rd_en) begin
      q <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/spram_ext.sv
// Single-port RAM with zero-fill sweep control, byte enables and a
// selectable 1- or 2-cycle read latency.
module spram_ext
  import spram_pkg::*;
#(
  parameter int numwords_a     = 256,
  parameter int widthad_a      = 8,
  parameter int width_a        = 32,
  parameter int byte_width     = 8,
  parameter int read_latency   = 1,
  parameter int clear_on_reset = 1
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  input  logic [widthad_a-1:0]          address_a,
  input  logic [width_a-1:0]            data_a,
  input  logic [width_a/byte_width-1:0] byteena_a,
  input  logic                          wren_a,
  input  logic                          rden_a,
  output logic [width_a-1:0]            q_a,
  output logic                          q_valid_a,
  input  logic                          clear_req,
  output logic                          ready_a
);

  localparam int LANES = lane_count(width_a, byte_width);
  localparam int LAT   = (read_latency >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  localparam logic [widthad_a-1:0] LAST_ADDR = widthad_a'(numwords_a - 1);
  localparam state_t RST_STATE = (clear_on_reset != 0) ? ST_CLEAR : ST_IDLE;

  state_t               state, state_nxt;
  logic [widthad_a-1:0] sweep_cnt;
  logic                 sweep_last;
  logic                 sweep_we;
  logic                 wr_acc, rd_acc;

  logic                 core_wr;
  logic [widthad_a-1:0] core_addr;
  logic [width_a-1:0]   core_wdata;
  logic [LANES-1:0]     core_be;
  logic [width_a-1:0]   core_q_p0;
  logic                 vld_p0;

  assign sweep_last = (sweep_cnt == LAST_ADDR);

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_req)  state_nxt = ST_CLEAR;
      ST_CLEAR: if (sweep_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_a  = 1'b0;
    sweep_we = 1'b0;
    case (state)
      ST_IDLE:  ready_a  = 1'b1;
      ST_CLEAR: sweep_we = 1'b1;
      default:  ready_a  = 1'b0;
    endcase
  end

  // The sweep always starts from address 0, including after a reset mid-sweep.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      sweep_cnt <= '0;
    end else if (sweep_we && !sweep_last) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end else begin
      sweep_cnt <= '0;
    end
  end

  assign wr_acc = ready_a & wren_a;
  assign rd_acc = ready_a & rden_a;

  always_comb begin
    core_wr    = wr_acc;
    core_addr  = address_a;
    core_wdata = data_a;
    core_be    = byteena_a;
    if (sweep_we) begin
      core_wr    = 1'b1;
      core_addr  = sweep_cnt;
      core_wdata = '0;
      core_be    = '1;
    end
  end

  spram_core #(
    .numwords   (numwords_a),
    .widthad    (widthad_a),
    .width      (width_a),
    .byte_width (byte_width),
    .lanes      (LANES)
  ) u_core (
    .clk   (clock_in),
    .rst_n (reset_in),
    .wr_en (core_wr),
    .rd_en (rd_acc),
    .addr  (core_addr),
    .wdata (core_wdata),
    .be    (core_be),
    .q     (core_q_p0)
  );

  // Stage p0: valid tracks the array's registered read data.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_acc;
    end
  end

  generate
    if (LAT == RD_LAT_MAX) begin : g_lat2
      logic [width_a-1:0] q_p1;
      logic               vld_p1;

      // Stage p1: extra output register, loaded only with valid data so q_a holds.
      always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
          vld_p1 <= 1'b0;
          q_p1   <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            q_p1 <= core_q_p0;
          end
        end
      end

      assign q_a       = q_p1;
      assign q_valid_a = vld_p1;
    end else begin : g_lat1
      assign q_a       = core_q_p0;
      assign q_valid_a = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_spram_ext.sv
// Bench for spram_ext: a 1-cycle and a 2-cycle instance share stimulus and
// are compared against a word-array reference model.
module tb_spram_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  addr;
  logic [31:0] data;
  logic [3:0]  be;
  logic        wren, rden, clr;
  logic [31:0] qa_a, qa_b;
  logic        qv_a, qv_b, rdy_a, rdy_b;

  logic [31:0] ref_mem [0:255];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  spram_ext #(
    .numwords_a(256), .widthad_a(9), .width_a(32), .byte_width(8),
    .read_latency(1), .clear_on_reset(1)
  ) dut_a (
    .clock_in(clk), .reset_in(rst_n), .address_a(addr), .data_a(data),
    .byteena_a(be), .wren_a(wren), .rden_a(rden), .q_a(qa_a),
    .q_valid_a(qv_a), .clear_req(clr), .ready_a(rdy_a)
  );

  spram_ext #(
    .numwords_a(256), .widthad_a(9), .width_a(32), .byte_width(8),
    .read_latency(2), .clear_on_reset(1)
  ) dut_b (
    .clock_in(clk), .reset_in(rst_n), .address_a(addr), .data_a(data),
    .byteena_a(be), .wren_a(wren), .rden_a(rden), .q_a(qa_b),
    .q_valid_a(qv_b), .clear_req(clr), .ready_a(rdy_b)
  );

  task automatic model_write(input logic [8:0] ad, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    if (ad < 9'd256) ref_mem[ad[7:0]] = (ref_mem[ad[7:0]] & ~m) | (d & m);
  endtask

  function automatic logic [31:0] expect_rd(input logic [8:0] ad);
    return (ad < 9'd256) ? ref_mem[ad[7:0]] : 32'd0;
  endfunction

  task automatic write_word(input logic [8:0] ad, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    wren = 1'b1; rden = 1'b0; clr = 1'b0; addr = ad; data = d; be = b;
    model_write(ad, d, b);
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic read_both(input logic [8:0] ad,
                           output logic va1, output logic [31:0] qa1, output logic vb1,
                           output logic va2, output logic [31:0] qa2,
                           output logic vb2, output logic [31:0] qb2);
    @(negedge clk);
    wren = 1'b0; rden = 1'b1; clr = 1'b0; addr = ad;
    @(negedge clk);
    va1 = qv_a; qa1 = qa_a; vb1 = qv_b;
    rden = 1'b0;
    @(negedge clk);
    va2 = qv_a; qa2 = qa_a; vb2 = qv_b; qb2 = qa_b;
  endtask

  task automatic test_reset();
    int na, nb;
    logic va1, vb1, va2, vb2;
    logic [31:0] qa1, qa2, qb2;
    repeat (3) @(negedge clk);
    vecs++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || qv_a !== 1'b0 || qv_b !== 1'b0 ||
        qa_a !== 32'd0 || qa_b !== 32'd0) begin
      errs++;
      $display("FAIL reset_state rdy=%b/%b qv=%b/%b q=%h/%h want all 0",
               rdy_a, rdy_b, qv_a, qv_b, qa_a, qa_b);
    end
    rst_n = 1'b1;
    na = -1; nb = -1;
    for (int n = 0; n <= 600 && (na < 0 || nb < 0); n++) begin
      if (n > 0) @(negedge clk);
      if (rdy_a === 1'b1 && na < 0) na = n;
      if (rdy_b === 1'b1 && nb < 0) nb = n;
    end
    vecs++;
    if (na != 256 || nb != 256) begin
      errs++;
      $display("FAIL reset_sweep_len got %0d/%0d cycles want 256", na, nb);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    for (int k = 0; k < 3; k++) begin
      logic [8:0] ad;
      ad = (k == 0) ? 9'd0 : (k == 1) ? 9'd128 : 9'd255;
      read_both(ad, va1, qa1, vb1, va2, qa2, vb2, qb2);
      vecs++;
      if (va1 !== 1'b1 || qa1 !== 32'd0 || vb2 !== 1'b1 || qb2 !== 32'd0) begin
        errs++;
        $display("FAIL reset_zero addr=%0d got %b:%h / %b:%h want 1:00000000", ad, va1, qa1, vb2, qb2);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic va1, vb1, va2, vb2;
    logic [31:0] qa1, qa2, qb2;
    write_word(9'd5, 32'hAABBCCDD, 4'b1111);
    write_word(9'd5, 32'h11223344, 4'b0101);
    read_both(9'd5, va1, qa1, vb1, va2, qa2, vb2, qb2);
    vecs++;
    if (va1 !== 1'b1 || qa1 !== 32'hAA22CC44 || va2 !== 1'b0 || qa2 !== 32'hAA22CC44) begin
      errs++;
      $display("FAIL byteena_lat1 got v=%b q=%h hold v=%b q=%h want AA22CC44", va1, qa1, va2, qa2);
    end
    vecs++;
    if (vb1 !== 1'b0 || vb2 !== 1'b1 || qb2 !== expect_rd(9'd5)) begin
      errs++;
      $display("FAIL byteena_lat2 got early=%b v=%b q=%h want %h", vb1, vb2, qb2, expect_rd(9'd5));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dv [1:3];
    for (int i = 1; i <= 3; i++) begin
      dv[i] = $urandom;
      write_word(9'(i), dv[i], 4'b1111);
    end
    @(negedge clk);
    rden = 1'b1; wren = 1'b0; addr = 9'd1;
    for (int s = 1; s <= 5; s++) begin
      logic ea, eb;
      @(negedge clk);
      ea = (s <= 3);
      eb = (s >= 2 && s <= 4);
      vecs++;
      if (qv_a !== ea || (ea && qa_a !== dv[s])) begin
        errs++;
        $display("FAIL b2b_lat1 cycle+%0d got v=%b q=%h want v=%b", s, qv_a, qa_a, ea);
      end
      vecs++;
      if (qv_b !== eb || (eb && qa_b !== dv[s-1])) begin
        errs++;
        $display("FAIL b2b_lat2 cycle+%0d got v=%b q=%h want v=%b", s, qv_b, qa_b, eb);
      end
      if (s < 3) addr = 9'(s + 1);
      else rden = 1'b0;
    end
  endtask

  task automatic test_read_first();
    logic va1, vb1, va2, vb2, v1, v2;
    logic [31:0] qa1, qa2, qb2, q1, q2;
    write_word(9'd7, 32'h9, 4'b1111);
    @(negedge clk);
    wren = 1'b1; rden = 1'b1; addr = 9'd7; data = 32'h5; be = 4'b1111;
    @(negedge clk);
    v1 = qv_a; q1 = qa_a;
    wren = 1'b0; rden = 1'b0;
    model_write(9'd7, 32'h5, 4'b1111);
    @(negedge clk);
    v2 = qv_b; q2 = qa_b;
    vecs++;
    if (v1 !== 1'b1 || q1 !== 32'h9 || v2 !== 1'b1 || q2 !== 32'h9) begin
      errs++;
      $display("FAIL read_first got %b:%h / %b:%h want 1:00000009", v1, q1, v2, q2);
    end
    read_both(9'd7, va1, qa1, vb1, va2, qa2, vb2, qb2);
    vecs++;
    if (va1 !== 1'b1 || qa1 !== 32'h5 || vb2 !== 1'b1 || qb2 !== 32'h5) begin
      errs++;
      $display("FAIL after_write got %b:%h / %b:%h want 1:00000005", va1, qa1, vb2, qb2);
    end
  endtask

  task automatic test_out_of_range();
    logic va1, vb1, va2, vb2;
    logic [31:0] qa1, qa2, qb2;
    write_word(9'd44, 32'h12345678, 4'b1111);
    write_word(9'd300, 32'hFFFF_FFFF, 4'b1111);
    read_both(9'd300, va1, qa1, vb1, va2, qa2, vb2, qb2);
    vecs++;
    if (va1 !== 1'b1 || qa1 !== 32'd0 || vb2 !== 1'b1 || qb2 !== 32'd0) begin
      errs++;
      $display("FAIL oob_read got %b:%h / %b:%h want 1:00000000", va1, qa1, vb2, qb2);
    end
    read_both(9'd44, va1, qa1, vb1, va2, qa2, vb2, qb2);
    vecs++;
    if (qa1 !== expect_rd(9'd44) || qb2 !== expect_rd(9'd44) || va1 !== 1'b1 || vb2 !== 1'b1) begin
      errs++;
      $display("FAIL oob_alias got %h / %h want %h", qa1, qb2, expect_rd(9'd44));
    end
  endtask

  task automatic test_random();
    logic va1, vb1, va2, vb2;
    logic [31:0] qa1, qa2, qb2, ex;
    logic [8:0] ad;
    for (int it = 0; it < 150; it++) begin
      ad = 9'($urandom_range(0, 299));
      if ($urandom_range(0, 3) < 2) begin
        write_word(ad, $urandom, 4'($urandom));
      end else begin
        read_both(ad, va1, qa1, vb1, va2, qa2, vb2, qb2);
        ex = expect_rd(ad);
        vecs++;
        if (va1 !== 1'b1 || qa1 !== ex || va2 !== 1'b0 || qa2 !== ex) begin
          errs++;
          $display("FAIL rand_lat1 addr=%0d got v=%b q=%h hold v=%b q=%h want %h", ad, va1, qa1, va2, qa2, ex);
        end
        vecs++;
        if (vb1 !== 1'b0 || vb2 !== 1'b1 || qb2 !== ex) begin
          errs++;
          $display("FAIL rand_lat2 addr=%0d got early=%b v=%b q=%h want %h", ad, vb1, vb2, qb2, ex);
        end
      end
    end
  endtask

  task automatic test_clear_sweep();
    int n, bad;
    logic v1, v2, r1;
    logic [31:0] q1, q2;
    logic va1, vb1, va2, vb2;
    logic [31:0] qa1, qa2, qb2;
    write_word(9'd10, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    rden = 1'b1; wren = 1'b0; addr = 9'd10; clr = 1'b1;
    @(negedge clk);
    r1 = rdy_a; v1 = qv_a; q1 = qa_a;
    rden = 1'b0; clr = 1'b0;
    @(negedge clk);
    v2 = qv_b; q2 = qa_b;
    vecs++;
    if (r1 !== 1'b0 || v1 !== 1'b1 || q1 !== 32'hDEADBEEF || v2 !== 1'b1 || q2 !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL drain got rdy=%b %b:%h / %b:%h want 0 1:DEADBEEF", r1, v1, q1, v2, q2);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      wren = 1'($urandom_range(0, 1)); rden = 1'($urandom_range(0, 1));
      clr = 1'($urandom_range(0, 1)); addr = 9'($urandom_range(0, 511));
      data = $urandom; be = 4'($urandom);
      @(negedge clk);
      if (qv_a !== 1'b0 || qv_b !== 1'b0 || rdy_a !== 1'b0 || rdy_b !== 1'b0) bad++;
    end
    rst_n = 1'b0;
    wren = 1'b0; rden = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if (qa_a !== 32'd0 || qa_b !== 32'd0 || qv_a !== 1'b0 || qv_b !== 1'b0 || rdy_a !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_sweep got q=%h/%h qv=%b/%b rdy=%b want 0", qa_a, qa_b, qv_a, qv_b, rdy_a);
    end
    rst_n = 1'b1;
    n = 0;
    while (!(rdy_a === 1'b1 && rdy_b === 1'b1) && n < 600) begin
      wren = 1'($urandom_range(0, 1)); rden = 1'($urandom_range(0, 1));
      addr = 9'($urandom_range(0, 511)); data = $urandom; be = 4'($urandom);
      clr = (n == 100);
      @(negedge clk);
      n++;
      if (qv_a !== 1'b0 || qv_b !== 1'b0 || rdy_a !== rdy_b) bad++;
    end
    wren = 1'b0; rden = 1'b0; clr = 1'b0;
    vecs++;
    if (n != 256) begin
      errs++;
      $display("FAIL sweep_restart_len got %0d cycles want 256", n);
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL sweep_quiet got %0d bad cycles want 0", bad);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) begin
      read_both(9'(i), va1, qa1, vb1, va2, qa2, vb2, qb2);
      vecs++;
      if (va1 !== 1'b1 || qa1 !== expect_rd(9'(i)) || vb2 !== 1'b1 || qb2 !== expect_rd(9'(i))) begin
        errs++;
        $display("FAIL cleared addr=%0d got %b:%h / %b:%h want 1:00000000", i, va1, qa1, vb2, qb2);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wren = 1'b0; rden = 1'b0; clr = 1'b0;
    addr = '0; data = '0; be = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_read_first();
    test_out_of_range();
    test_random();
    test_clear_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/spram_ext.md
SPRAM_EXT -- requirements
Module: spram_ext

Interface
REQ-001 SHALL have parameter numwords_a, default 256, meaning number of words.
REQ-002 SHALL have parameter widthad_a, default 8, meaning address width.
REQ-003 SHALL have parameter width_a, default 32, meaning data width, a multiple of byte_width.
REQ-004 SHALL have parameter byte_width, default 8, meaning bits per byte-enable lane.
REQ-005 SHALL have parameter read_latency, default 1, meaning read latency of 1 or 2 cycles.
REQ-006 SHALL have parameter clear_on_reset, default 1, meaning zero-fill the array after reset when 1.
REQ-007 SHALL have port clock_in, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_in, input, 1, an asynchronous active-low reset.
REQ-009 SHALL have port address_a, input, widthad_a, the access address.
REQ-010 SHALL have port data_a, input, width_a, the write data.
REQ-011 SHALL have port byteena_a, input, width_a/byte_width, the per-lane write enables.
REQ-012 SHALL have port wren_a, input, 1, the write request.
REQ-013 SHALL have port rden_a, input, 1, the read request.
REQ-014 SHALL have port q_a, output, width_a, the read data.
REQ-015 SHALL have port q_valid_a, output, 1, a one-cycle pulse marking q_a valid.
REQ-016 SHALL have port clear_req, input, 1, a pulse that starts a zero-fill sweep.
REQ-017 SHALL have port ready_a, output, 1, high when user accesses are accepted.

Function
REQ-018 SHALL run a control FSM with states IDLE and CLEAR; ready_a is 1 only in IDLE.
REQ-019 SHALL, in CLEAR, write all-zero (all lanes) to addresses 0..numwords_a-1, one per cycle, using an internal sweep counter.
REQ-020 SHALL go from CLEAR to IDLE in the cycle after address numwords_a-1 is written; sweep length is exactly numwords_a cycles.
REQ-021 SHALL start a sweep when clear_req=1 in IDLE, going to CLEAR on the next edge; clear_req in CLEAR is ignored.
REQ-022 SHALL ignore wren_a/rden_a while ready_a=0: no write, no q_valid_a.
REQ-023 SHALL accept a write when ready_a & wren_a, updating only lanes with byteena_a[i]=1; other lanes keep their old contents.
REQ-024 SHALL accept a read when ready_a & rden_a and assert q_valid_a exactly read_latency cycles later with the addressed word.
REQ-025 SHALL, for a same-cycle read and write to one address, return the pre-write data (read-first).
REQ-026 SHALL accept one access per cycle with no back-pressure; back-to-back reads produce back-to-back q_valid_a pulses.
REQ-027 SHALL drop writes with address_a >= numwords_a; reads of such addresses SHALL return zero with q_valid_a still asserted.
REQ-028 SHALL hold q_a at its last value when q_valid_a=0.
REQ-029 SHALL drain in-flight reads already accepted when a sweep starts, so their q_valid_a pulses still appear.

Reset
REQ-030 SHALL, while reset_in=0, force q_a=0, q_valid_a=0, the read pipeline valid bits=0 and the sweep counter=0.
REQ-031 SHALL hold the FSM in CLEAR during reset when clear_on_reset=1 (ready_a=0), otherwise in IDLE (ready_a=1).
REQ-032 SHALL restart a sweep interrupted by reset from address 0; array contents are not reset otherwise.

Structure
REQ-033 SHALL place the FSM state enum, the read-latency limits and a lane-count helper constant in shared package spram_pkg.
REQ-034 SHALL instantiate one sub-module spram_core, an inferred byte-enabled, read-first single-port array with 1-cycle registered output.
REQ-035 SHALL implement read_latency=2 as one extra output register plus a valid pipeline in spram_ext.

Verification
REQ-036 SHALL test: reset with clear_on_reset=1, numwords_a=256 -> ready_a low for exactly 256 cycles, then reads of addresses 0, 128 and 255 return 0.
REQ-037 SHALL test: write 0xAABBCCDD to address 5 with byteena 4'b1111, then 0x11223344 with 4'b0101 -> a read returns 0xAA22CC44.
REQ-038 SHALL test: read_latency=2, reads of addresses 1, 2, 3 on consecutive cycles -> q_valid_a high on cycles +2, +3, +4 with matching data.
REQ-039 SHALL test: same-cycle write 0x5 and read of address 7 holding 0x9 -> q_a=0x9, and a following read returns 0x5.
REQ-040 SHALL test: clear_req mid-traffic with reset_in pulsed low during the sweep -> the sweep restarts at 0, no q_valid_a during it, and all words are zero afterwards.
REQ-041 SHALL test: write 0xFFFF_FFFF to address 300 with widthad_a=9, numwords_a=256 -> no array change, and a read of 300 returns 0 with q_valid_a.
